// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: shares port A of the character video RAM between the
// status-line writer (req 0), the falling-character renderer (req 1) and the
// hit/miss marker flasher (req 2), and owns a full-screen clear engine.
// Optional feature macro: VRAM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, fixed priority req 0 > req 1 > req 2 is used.
// All outputs are registered; a grant for a request sampled at one edge is
// visible in the following cycle.
module vram_write_arbiter #(
  parameter int CELLS = 2100,
  parameter int AW    = 12,
  parameter int DW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  output logic [2:0]    gnt,
  input  logic          clear_start,
  output logic          clear_busy,
  output logic          clear_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          oob_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit so addresses up to 2**AW-1 compare correctly against CELLS.
  localparam logic [AW:0]   CELLS_X   = (AW+1)'(CELLS);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  state_t          state, state_nxt;
  logic [2:0]      gnt_nxt;
  logic            wr_en_nxt;
  logic [AW-1:0]   wr_addr_nxt;
  logic [DW-1:0]   wr_data_nxt;
  logic            clear_busy_nxt;
  logic            clear_done_nxt;
  logic            oob_err_nxt;

  logic [2:0]      elig;
  logic [2:0]      arb_gnt;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            sel_in_range;
  logic            do_arb;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // Index of the most recently granted requester; priority starts one past it.
  logic [1:0]      rr_ptr, rr_ptr_nxt;

  function automatic logic [2:0] pick_rr(input logic [2:0] e, input logic [1:0] last);
    logic [2:0] g;
    logic [1:0] idx;
    g   = '0;
    idx = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (g == 3'b000 && e[idx]) g[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return g;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] g);
    logic [1:0] i;
    i = 2'd0;
    if (g[1]) i = 2'd1;
    if (g[2]) i = 2'd2;
    return i;
  endfunction
`else
  function automatic logic [2:0] pick_fixed(input logic [2:0] e);
    logic [2:0] g;
    g = 3'b000;
    if (e[0])      g = 3'b001;
    else if (e[1]) g = 3'b010;
    else if (e[2]) g = 3'b100;
    return g;
  endfunction
`endif

  // A requester granted last cycle sits out one cycle so a dropped or changed
  // request is never served twice.
  assign elig = req & ~gnt;

  // Pick at most one eligible requester and route its address/data.
  always_comb begin
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    arb_gnt = pick_rr(elig, rr_ptr);
`else
    arb_gnt = pick_fixed(elig);
`endif
    sel_addr = addr0;
    sel_data = data0;
    case (arb_gnt)
      3'b010: begin
        sel_addr = addr1;
        sel_data = data1;
      end
      3'b100: begin
        sel_addr = addr2;
        sel_data = data2;
      end
      default: begin
        sel_addr = addr0;
        sel_data = data0;
      end
    endcase
    sel_in_range = ({1'b0, sel_addr} < CELLS_X);
  end

  // Next-state and next-output logic for the IDLE / CLEAR / DONE controller.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = 3'b000;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    clear_busy_nxt = clear_busy;
    clear_done_nxt = 1'b0;
    oob_err_nxt    = oob_err;
    do_arb         = 1'b0;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
    rr_ptr_nxt     = rr_ptr;
`endif

    case (state)
      IDLE: begin
        if (clear_start) begin
          // Clear wins over any pending request; first cell written next cycle.
          state_nxt      = CLEAR;
          clear_busy_nxt = 1'b1;
          wr_en_nxt      = 1'b1;
          wr_addr_nxt    = '0;
          wr_data_nxt    = '0;
          oob_err_nxt    = 1'b0;
        end else begin
          do_arb = 1'b1;
        end
      end
      CLEAR: begin
        // wr_addr doubles as the clear cell counter.
        if (wr_addr == LAST_CELL) begin
          state_nxt      = DONE;
          clear_busy_nxt = 1'b0;
          clear_done_nxt = 1'b1;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = wr_addr + 1'b1;
          wr_data_nxt = '0;
        end
      end
      DONE: begin
        // Requests held through the clear are arbitrated here so the first
        // grant lands in the cycle right after clear_done.
        state_nxt = IDLE;
        do_arb    = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (do_arb && (arb_gnt != 3'b000)) begin
      gnt_nxt     = arb_gnt;
      wr_addr_nxt = sel_addr;
      wr_data_nxt = sel_data;
      // Out-of-range requests are still granted so the requester never stalls.
      if (sel_in_range) wr_en_nxt   = 1'b1;
      else              oob_err_nxt = 1'b1;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      rr_ptr_nxt = onehot_to_idx(arb_gnt);
`endif
    end
  end

  // State and output registers; reset abandons any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      clear_busy <= clear_busy_nxt;
      clear_done <= clear_done_nxt;
      oob_err    <= oob_err_nxt;
    end
  end

`ifdef VRAM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer; reset to 2 so the first priority goes to req 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= 2'd2;
    else        rr_ptr <= rr_ptr_nxt;
  end
`endif

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Shares the single write port (port A) of the 2100-cell character video RAM between three requesters: the header/footer status-line writer (req 0), the falling-character renderer (req 1) and the hit/miss marker flasher (req 2). It also contains a clear engine that sweeps every cell to zero on command. It sits between the game-logic writers and `video_ram` port A; the read side (port B, VGA scan-out) is untouched.

## Interface
Parameters:
- `CELLS`, 2100: number of character cells (70 columns × 30 rows); valid addresses are 0..CELLS-1.
- `AW`, 12: cell address width.
- `DW`, 11: cell word width ({color[2:0], ascii[7:0]}).

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  3  per-requester write request, level.
- `addr0`, `addr1`, `addr2`  in  AW  cell address for requester i; must be stable while `req[i]` is high.
- `data0`, `data1`, `data2`  in  DW  cell word for requester i; must be stable while `req[i]` is high.
- `gnt`  out  3  one-hot, one-cycle grant pulse.
- `clear_start`  in  1  single-cycle pulse that starts a full-screen clear.
- `clear_busy`  out  1  high while the clear engine owns the port.
- `clear_done`  out  1  one-cycle pulse after the last cell is cleared.
- `wr_en`  out  1  video RAM write enable (port A).
- `wr_addr`  out  AW  video RAM write address.
- `wr_data`  out  DW  video RAM write data.
- `oob_err`  out  1  sticky flag: a granted request carried addr ≥ CELLS.

## Operation
- FSM states:
  - **IDLE**: arbitrate among `req`.
  - **CLEAR**: clear engine owns the port.
  - **DONE**: one cycle; pulse `clear_done`, return to IDLE.
- IDLE → CLEAR on `clear_start`. A clear cell counter loads 0, `clear_busy` rises.
- CLEAR: each cycle write addr = counter, data = 0, `wr_en` = 1, then increment. After writing CELLS-1, go to DONE.
- `clear_start` while in CLEAR or DONE is ignored.
- `clear_start` in the same cycle as pending requests: the clear wins, and no grant is issued that cycle.
- During CLEAR/DONE, `gnt` = 0. Pending requests stay pending and are served after the return to IDLE.
- IDLE arbitration selects at most one eligible requester per cycle. A requester is eligible if `req[i]` = 1 and it was not granted in the previous cycle.
  - The eligibility blackout means a requester that drops or changes `req` in the cycle after its grant is never double-served.
- On grant of requester i:
  - `gnt[i]` = 1 for one cycle.
  - `wr_addr`/`wr_data` take `addr_i`/`data_i`.
  - `wr_en` = 1 only if `addr_i` < CELLS. Otherwise `wr_en` = 0 and `oob_err` is set.
  - An out-of-range request is still granted so the requester does not stall.
- `oob_err` clears only on reset or on `clear_start` acceptance.
- No grant in a cycle: `wr_en` = 0. `wr_addr`/`wr_data` hold their last value.

## Timing
- All outputs are registered.
- Reset values: `gnt` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `clear_busy` = 0, `clear_done` = 0, `oob_err` = 0, state = IDLE, round-robin pointer = 2.
- Request latency: `req[i]` sampled high at edge N → `gnt[i]`, `wr_en`, `wr_addr` and `wr_data` valid during cycle N+1 (i.e. after edge N). RAM write completes at edge N+1.
- Per-requester throughput: at most one write every 2 cycles. Aggregate throughput: one write per cycle.
- Clear: `clear_start` at edge N → `clear_busy` = 1 and first write (addr 0) in cycle N+1. Last write (addr CELLS-1) in cycle N+CELLS.
  - `clear_done` = 1 and `clear_busy` = 0 in cycle N+CELLS+1.
  - Earliest grant is in cycle N+CELLS+2.
- Reset mid-clear: immediate return to IDLE. No `clear_done`; partially cleared RAM is left as is.

## Configuration
- `VRAM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. Priority starts at (last granted index + 1) mod 3, and the pointer updates on every grant. After reset the first priority is req 0.
- Not defined: fixed priority, req 0 > req 1 > req 2. The pointer is absent. The eligibility blackout still applies, so req 0 streaming back-to-back yields alternate cycles to lower priorities.

## Test plan
- Reset, then `req` = 3'b010 with `addr1` = 75, `data1` = 11'h141 held 1 cycle → `gnt` = 3'b010 in the next cycle; `wr_en` = 1, `wr_addr` = 75, `wr_data` = 11'h141; `oob_err` = 0.
- All three `req` held high for 6 cycles with round-robin enabled → grant order 0,1,2,0,1,2. With the macro undefined → 0,1,0,1,0,1 (req 2 starves under the blackout pattern).
- `req[0]` held high continuously (addr 5) → `gnt[0]` pulses every other cycle and never in consecutive cycles.
- `req[2]` with `addr2` = 2100 → `gnt[2]` pulses, `wr_en` = 0, `oob_err` = 1 and stays set until the next `clear_start`.
- `clear_start` with `req[1]` pending → 2100 writes of data 0 at addr 0..2099 on consecutive cycles, `clear_busy` high throughout, then `clear_done` pulses once. `gnt[1]` follows 1 cycle later with its original addr/data.
- Assert `rst_n` low at clear cell 1000 → all outputs at reset values at once, no `clear_done`. After release, a new request is granted normally.
